// File: rtl/ddr_pkg.sv
// ddr_pkg: shared types and constants for the controller read-capture path.
//   BL_BC4 / BL_BL8 : the two legal burst lengths (beats)
//   rd_cap_state_e  : capture FSM states
//   rd_err_e        : error codes reported alongside rd_err
package ddr_pkg;

    localparam int BL_BC4 = 4;
    localparam int BL_BL8 = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PRE,
        BURST,
        DONE
    } rd_cap_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_OVERLAP = 2'b10,
        ERR_BL      = 2'b11
    } rd_err_e;

endpackage

// File: rtl/rd_beat_assembler.sv
// rd_beat_assembler: beat counter plus byte-slot writer.
//   clk, rst      : clock, asynchronous active-high reset
//   i_clear       : zero the assembled word and the beat counter
//   i_enable      : capture i_dq into slot o_beat_cnt, then advance the count
//   i_dq          : one byte lane of read data
//   o_rd_data     : assembled word, beat k in bits [k*DQ_W +: DQ_W]
//   o_beat_cnt    : beats captured since the last clear
module rd_beat_assembler #(
    parameter int DQ_W   = 8,
    parameter int BL_MAX = 8,
    localparam int CNT_W = $clog2(BL_MAX) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_enable,
    input  logic [DQ_W-1:0]        i_dq,
    output logic [BL_MAX*DQ_W-1:0] o_rd_data,
    output logic [CNT_W-1:0]       o_beat_cnt
);

    logic [BL_MAX-1:0][DQ_W-1:0] r_data;
    logic [CNT_W-1:0]            r_cnt;

    // Writes past BL_MAX are dropped so a stray enable cannot wrap the slot index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_enable && (r_cnt < CNT_W'(BL_MAX))) begin
            r_data[r_cnt[CNT_W-2:0]] <= i_dq;
            r_cnt                    <= r_cnt + CNT_W'(1);
        end
    end

    assign o_rd_data  = r_data;
    assign o_beat_cnt = r_cnt;

endmodule

// File: rtl/ctrl_rd_capture.sv
// ctrl_rd_capture: controller-side DDR read-data capture stage.
// Arms on a read command, waits for the (1,0) DQS preamble, captures one DQ
// byte per clock for the programmed burst and presents the little-endian
// burst word with a one-cycle rd_valid pulse. Reports timeout, overlapping
// commands and illegal burst/preamble settings on rd_err/err_code.
//   CK_t, reset          : clock, asynchronous active-high reset
//   rd_start             : read issued (one-cycle pulse)
//   burst_length         : 4 or 8 beats, sampled with rd_start
//   preamble             : 1 or 2 preamble cycles, sampled with rd_start
//   dqs_t, dqs_c         : data strobe pair
//   dq                   : read data byte lane
//   rd_data, rd_valid    : assembled burst and its completion pulse
//   rd_err, err_code     : error pulse and code (01 timeout, 10 overlap, 11 BL)
//   busy                 : high whenever not IDLE
module ctrl_rd_capture
    import ddr_pkg::*;
#(
    parameter int DQ_W    = 8,
    parameter int BL_MAX  = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                   CK_t,
    input  logic                   reset,
    input  logic                   rd_start,
    input  logic [3:0]             burst_length,
    input  logic [1:0]             preamble,
    input  logic                   dqs_t,
    input  logic                   dqs_c,
    input  logic [DQ_W-1:0]        dq,
    output logic [BL_MAX*DQ_W-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   rd_err,
    output logic [1:0]             err_code,
    output logic                   busy
);

    localparam int CNT_W = $clog2(BL_MAX) + 1;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    rd_cap_state_e    r_state, w_state_nxt;
    logic [CNT_W-1:0] r_bl;
    logic             r_pre2;
    logic [TMR_W-1:0] r_timer;
    logic             r_err;
    logic [1:0]       r_err_code;

    logic             w_clear, w_enable, w_legal, w_strobe, w_tmo, w_last_beat;
    rd_err_e          w_err;
    logic [CNT_W-1:0] w_beat_cnt;

    assign w_legal  = ((burst_length == 4'(BL_BC4)) || (burst_length == 4'(BL_BL8)))
                    && ((preamble == 2'd1) || (preamble == 2'd2));
    assign w_strobe = dqs_t & ~dqs_c;
    // True on the ARM cycle whose increment brings the timer to TIMEOUT.
    assign w_tmo    = (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_last_beat = (w_beat_cnt == (r_bl - CNT_W'(1)));

    rd_beat_assembler #(
        .DQ_W   (DQ_W),
        .BL_MAX (BL_MAX)
    ) u_asm (
        .clk        (CK_t),
        .rst        (reset),
        .i_clear    (w_clear),
        .i_enable   (w_enable),
        .i_dq       (dq),
        .o_rd_data  (rd_data),
        .o_beat_cnt (w_beat_cnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_enable    = 1'b0;
        w_err       = ERR_NONE;
        case (r_state)
            IDLE: begin
                if (rd_start) begin
                    if (w_legal) begin
                        w_state_nxt = ARM;
                        w_clear     = 1'b1;
                    end else begin
                        w_err = ERR_BL;
                    end
                end
            end
            ARM: begin
                // A preamble seen on the final allowed cycle still wins over timeout.
                if (w_strobe) begin
                    w_state_nxt = r_pre2 ? PRE : BURST;
                end else if (w_tmo) begin
                    w_state_nxt = IDLE;
                    w_err       = ERR_TIMEOUT;
                end
            end
            PRE:   w_state_nxt = BURST;
            BURST: begin
                w_enable = 1'b1;
                if (w_last_beat) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Overlap is the lowest-priority error; a same-cycle timeout masks it.
        if ((r_state != IDLE) && rd_start && (w_err == ERR_NONE))
            w_err = ERR_OVERLAP;
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bl       <= '0;
            r_pre2     <= 1'b0;
            r_timer    <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_err      <= (w_err != ERR_NONE);
            r_err_code <= w_err;
            if (w_clear) begin
                r_bl    <= CNT_W'(burst_length);
                r_pre2  <= (preamble == 2'd2);
                r_timer <= '0;
            end else if ((r_state == ARM) && (r_timer != '1)) begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    assign rd_valid = (r_state == DONE);
    assign busy     = (r_state != IDLE);
    assign rd_err   = r_err;
    assign err_code = r_err_code;

endmodule

// File: tb/tb_ctrl_rd_capture.sv
module tb_ctrl_rd_capture;

    logic        CK_t = 1'b0;
    logic        reset = 1'b1;
    logic        rd_start = 1'b0;
    logic [3:0]  burst_length = 4'd0;
    logic [1:0]  preamble = 2'd0;
    logic        dqs_t = 1'b1;
    logic        dqs_c = 1'b1;
    logic [7:0]  dq = 8'h00;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        rd_err;
    logic [1:0]  err_code;
    logic        busy;

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;

    exp_t vq[$];
    exp_t eq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    ctrl_rd_capture #(.DQ_W(8), .BL_MAX(8), .TIMEOUT(32)) dut (
        .CK_t         (CK_t),
        .reset        (reset),
        .rd_start     (rd_start),
        .burst_length (burst_length),
        .preamble     (preamble),
        .dqs_t        (dqs_t),
        .dqs_c        (dqs_c),
        .dq           (dq),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_err       (rd_err),
        .err_code     (err_code),
        .busy         (busy)
    );

    initial forever #5 CK_t = ~CK_t;
    always @(posedge CK_t) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CK_t);
        #1;
    endtask

    task automatic start_rd(input logic [3:0] bl, input logic [1:0] pre);
        rd_start     = 1'b1;
        burst_length = bl;
        preamble     = pre;
        step();
        rd_start = 1'b0;
    endtask

    task automatic push_v(input logic [63:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        vq.push_back(e);
    endtask

    task automatic push_e(input logic [1:0] code, input int c);
        exp_t e;
        e.val = {62'd0, code};
        e.cyc = c;
        eq.push_back(e);
    endtask

    // Scoreboard side: every rd_valid / rd_err pulse must match the next queued expectation.
    always @(negedge CK_t) begin
        exp_t e;
        if (rd_valid) begin
            if (vq.size() == 0) chk("unexpected_rd_valid", 64'd1, 64'd0);
            else begin
                e = vq.pop_front();
                chk("rd_data", rd_data, e.val);
                chk("valid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (rd_err) begin
            if (eq.size() == 0) chk("unexpected_rd_err", {62'd0, err_code}, 64'd0);
            else begin
                e = eq.pop_front();
                chk("err_code", {62'd0, err_code}, e.val);
                chk("err_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        int t, p;

        // Reset state
        repeat (3) step();
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("rst_rd_err", {63'd0, rd_err}, 64'd0);
        chk("rst_err_code", {62'd0, err_code}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        step();

        // BL8, preamble 1, bytes 01..08
        start_rd(4'd8, 2'd1);
        chk("bl8_busy_arm", {63'd0, busy}, 64'd1);
        step(); step();
        dqs_t = 1'b1; dqs_c = 1'b0;
        step();
        p = cyc;
        dqs_c = 1'b1;
        push_v(64'h0807060504030201, p + 8);
        for (int i = 0; i < 8; i++) begin
            dq = 8'(i + 1);
            step();
        end
        dq = 8'hEE;
        step(); step();
        chk("bl8_busy_after", {63'd0, busy}, 64'd0);
        chk("bl8_hold", rd_data, 64'h0807060504030201);

        // BC4, preamble 2: upper slots must come back cleared
        start_rd(4'd4, 2'd2);
        step();
        dqs_t = 1'b1; dqs_c = 1'b0;
        step();
        p = cyc;
        step();
        dqs_c = 1'b1;
        push_v(64'h00000000DDCCBBAA, p + 5);
        for (int i = 0; i < 4; i++) begin
            dq = 8'hAA + 8'(i * 17);
            step();
        end
        dq = 8'h99;
        repeat (3) step();
        chk("bc4_hold", rd_data, 64'h00000000DDCCBBAA);
        chk("bc4_busy_after", {63'd0, busy}, 64'd0);

        // Timeout, with an overlapping rd_start on the timeout cycle (timeout wins)
        start_rd(4'd8, 2'd1);
        t = cyc;
        push_e(2'b01, t + 32);
        repeat (31) step();
        chk("tmo_busy_before", {63'd0, busy}, 64'd1);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        chk("tmo_busy_after", {63'd0, busy}, 64'd0);
        repeat (8) step();

        // Overlap during BURST and in DONE; first read must still complete
        start_rd(4'd8, 2'd1);
        step();
        dqs_t = 1'b1; dqs_c = 1'b0;
        step();
        p = cyc;
        dqs_c = 1'b1;
        push_v(64'h1716151413121110, p + 8);
        for (int i = 0; i < 8; i++) begin
            dq = 8'h10 + 8'(i);
            if (i == 2) begin
                rd_start = 1'b1; burst_length = 4'd4;
                push_e(2'b10, p + 3);
            end else begin
                rd_start = 1'b0;
            end
            step();
        end
        rd_start = 1'b1;
        push_e(2'b10, p + 9);
        step();
        rd_start = 1'b0;
        dqs_t = 1'b1; dqs_c = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dq = 8'($urandom_range(0, 255));
            step();
        end
        dqs_c = 1'b1;
        chk("ovl_busy_after", {63'd0, busy}, 64'd0);
        chk("ovl_hold", rd_data, 64'h1716151413121110);

        // Illegal burst length, then illegal preamble
        push_e(2'b11, cyc + 1);
        start_rd(4'd5, 2'd1);
        chk("bl5_busy", {63'd0, busy}, 64'd0);
        step();
        push_e(2'b11, cyc + 1);
        start_rd(4'd8, 2'd3);
        chk("pre3_busy", {63'd0, busy}, 64'd0);
        step(); step();
        chk("ill_hold", rd_data, 64'h1716151413121110);

        // Reset in the middle of a BL8 burst
        start_rd(4'd8, 2'd1);
        dqs_t = 1'b1; dqs_c = 1'b0;
        step();
        dqs_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dq = 8'h50 + 8'(i);
            step();
        end
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rd_data", rd_data, 64'd0);
        chk("mid_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("mid_rst_rd_err", {63'd0, rd_err}, 64'd0);
        chk("mid_rst_err_code", {62'd0, err_code}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            dq = 8'($urandom_range(0, 255));
            step();
        end
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_rd_data", rd_data, 64'd0);

        chk("valid_queue_empty", 64'(vq.size()), 64'd0);
        chk("err_queue_empty", 64'(eq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
